inference_job_scheduler: RTL and testbench

Sequences the accelerator datapath between the IPv4 receive parser and the inference core. It captures each completed frame from the receive parser, starts the core with the 784-byte image, waits for the result, and hands the result plus the requester's addresses to the transmit path. A one-deep pending slot absorbs one frame arriving while a job is in flight; further frames are dropped and counted.

---
 rtl/infernet_pkg.sv | 28 ++
 rtl/infer_job_slot.sv | 33 +++
 rtl/inference_job_scheduler.sv | 177 +++++++++++++++++
 tb/tb_inference_job_scheduler.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/infernet_pkg.sv
// Shared types and constants for the inference accelerator datapath.
package infernet_pkg;

  localparam int USER_DATA_BYTES = 785;
  localparam int IMAGE_BYTES     = 784;
  localparam int IP_ADDR_WIDTH   = 32;
  localparam int MAC_ADDR_WIDTH  = 48;
  localparam int TAG_WIDTH       = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_SEND  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]       tag;
    logic [IP_ADDR_WIDTH-1:0]   ip;
    logic [MAC_ADDR_WIDTH-1:0]  mac;
    logic [IMAGE_BYTES*8-1:0]   image;
  } infer_job_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/infer_job_slot.sv
// One job register (tag, addresses, image) with load enable and a valid flag.
module infer_job_slot
  import infernet_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic       i_clr,
  input  infer_job_t i_job,
  output infer_job_t o_job,
  output logic       o_valid
);

  infer_job_t r_job;
  logic       r_valid;

  // Load wins over clear so a drain-and-refill in one cycle keeps the slot valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_job   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_job   <= i_job;
      r_valid <= 1'b1;
    end else if (i_clr) begin
      r_valid <= 1'b0;
    end
  end

  assign o_job   = r_job;
  assign o_valid = r_valid;

endmodule

// File: rtl/inference_job_scheduler.sv
// Sequences frames from the RX parser through the inference core to the TX path.
// Core watchdog is compiled in when INFER_SCHED_TIMEOUT_EN is defined.
module inference_job_scheduler
  import infernet_pkg::*;
#(
  parameter int RESULT_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [USER_DATA_BYTES*8-1:0]  RX_DATA_FRAME,
  input  logic [IP_ADDR_WIDTH-1:0]      RX_SRC_IP_ADDRESS,
  input  logic [MAC_ADDR_WIDTH-1:0]     RX_SRC_MAC_ADDRESS,
  input  logic                          RX_FRAME_READY,
  output logic                          CORE_START,
  output logic [IMAGE_BYTES*8-1:0]      CORE_IMAGE,
  input  logic                          CORE_DONE,
  input  logic [RESULT_WIDTH-1:0]       CORE_RESULT,
  output logic                          TX_VALID,
  input  logic                          TX_READY,
  output logic [IP_ADDR_WIDTH-1:0]      TX_DST_IP_ADDRESS,
  output logic [MAC_ADDR_WIDTH-1:0]     TX_DST_MAC_ADDRESS,
  output logic [TAG_WIDTH-1:0]          TX_TAG,
  output logic [RESULT_WIDTH-1:0]       TX_RESULT,
  output logic                          BUSY,
  output logic [15:0]                   DROP_COUNT,
  output logic [15:0]                   TIMEOUT_COUNT
);

  sched_state_t            r_state;
  sched_state_t            w_state_nxt;
  infer_job_t              w_rx_job;
  infer_job_t              w_act_job;
  infer_job_t              w_pend_job;
  infer_job_t              w_act_din;
  logic                    w_pend_valid;
  logic                    w_act_valid_unused;
  logic                    w_act_load;
  logic                    w_act_clr;
  logic                    w_drain;
  logic                    w_rx_direct;
  logic                    w_pend_load;
  logic                    w_drop;
  logic                    w_tmo_hit;
  logic [RESULT_WIDTH-1:0] r_result;
  logic [15:0]             r_drop_cnt;

  always_comb begin
    w_rx_job       = '0;
    w_rx_job.tag   = RX_DATA_FRAME[TAG_WIDTH-1:0];
    w_rx_job.ip    = RX_SRC_IP_ADDRESS;
    w_rx_job.mac   = RX_SRC_MAC_ADDRESS;
    w_rx_job.image = RX_DATA_FRAME[USER_DATA_BYTES*8-1:8];
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // TX handshake: a result transfers in any cycle where TX_VALID && TX_READY;
  // TX_VALID and all TX_* data hold steady until that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_act_load  = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_pend_valid) begin
          w_act_load  = 1'b1;
          w_drain     = 1'b1;
          w_state_nxt = S_START;
        end else if (RX_FRAME_READY) begin
          w_act_load  = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: w_state_nxt = S_RUN;
      S_RUN: begin
        if (CORE_DONE || w_tmo_hit) w_state_nxt = S_SEND;
      end
      S_SEND: begin
        if (TX_READY) begin
          if (w_pend_valid) begin
            w_act_load  = 1'b1;
            w_drain     = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A frame not taken straight into active may refill a pending slot that drains this cycle.
  assign w_rx_direct = (r_state == S_IDLE) && !w_pend_valid && RX_FRAME_READY;
  assign w_pend_load = RX_FRAME_READY && !w_rx_direct && (!w_pend_valid || w_drain);
  assign w_drop      = RX_FRAME_READY && !w_rx_direct && w_pend_valid && !w_drain;
  assign w_act_din   = w_rx_direct ? w_rx_job : w_pend_job;
  assign w_act_clr   = (r_state == S_SEND) && TX_READY && !w_pend_valid;

  infer_job_slot u_active (
    .clk     (ACLK),
    .rst_n   (ARESET),
    .i_load  (w_act_load),
    .i_clr   (w_act_clr),
    .i_job   (w_act_din),
    .o_job   (w_act_job),
    .o_valid (w_act_valid_unused)
  );

  infer_job_slot u_pending (
    .clk     (ACLK),
    .rst_n   (ARESET),
    .i_load  (w_pend_load),
    .i_clr   (w_drain),
    .i_job   (w_rx_job),
    .o_job   (w_pend_job),
    .o_valid (w_pend_valid)
  );

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      r_result <= '0;
    end else if (r_state == S_RUN) begin
      if (CORE_DONE)      r_result <= CORE_RESULT;
      else if (w_tmo_hit) r_result <= '1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET)     r_drop_cnt <= '0;
    else if (w_drop) r_drop_cnt <= sat_inc16(r_drop_cnt);
  end

`ifdef INFER_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic [15:0]      r_tmo_count;

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET)                 r_tmo_cnt <= '0;
    else if (r_state == S_START) r_tmo_cnt <= '0;
    else if (r_state == S_RUN)   r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end

  // A CORE_DONE arriving in the final watchdog cycle takes precedence.
  assign w_tmo_hit = (r_state == S_RUN) && !CORE_DONE &&
                     (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET)        r_tmo_count <= '0;
    else if (w_tmo_hit) r_tmo_count <= sat_inc16(r_tmo_count);
  end

  assign TIMEOUT_COUNT = r_tmo_count;
`else
  logic w_tmo_param_unused;
  assign w_tmo_param_unused = (TIMEOUT_CYCLES == 0);
  assign w_tmo_hit          = 1'b0;
  assign TIMEOUT_COUNT      = 16'd0;
`endif

  assign CORE_START         = (r_state == S_START);
  assign TX_VALID           = (r_state == S_SEND);
  assign BUSY               = (r_state != S_IDLE);
  assign CORE_IMAGE         = w_act_job.image;
  assign TX_DST_IP_ADDRESS  = w_act_job.ip;
  assign TX_DST_MAC_ADDRESS = w_act_job.mac;
  assign TX_TAG             = w_act_job.tag;
  assign TX_RESULT          = r_result;
  assign DROP_COUNT         = r_drop_cnt;

endmodule

// File: tb/tb_inference_job_scheduler.sv
// Self-checking bench for inference_job_scheduler: vector table, corner sequences, random traffic.
`timescale 1ns/1ps
module tb_inference_job_scheduler;
  import infernet_pkg::*;

  localparam int RW    = 8;
  localparam int IMG_W = IMAGE_BYTES * 8;
  localparam int FRM_W = USER_DATA_BYTES * 8;

  logic             ACLK = 1'b0;
  logic             ARESET = 1'b0;
  logic [FRM_W-1:0] RX_DATA_FRAME = '0;
  logic [31:0]      RX_SRC_IP_ADDRESS = '0;
  logic [47:0]      RX_SRC_MAC_ADDRESS = '0;
  logic             RX_FRAME_READY = 1'b0;
  logic             CORE_START;
  logic [IMG_W-1:0] CORE_IMAGE;
  logic             CORE_DONE = 1'b0;
  logic [RW-1:0]    CORE_RESULT = '0;
  logic             TX_VALID;
  logic             TX_READY = 1'b0;
  logic [31:0]      TX_DST_IP_ADDRESS;
  logic [47:0]      TX_DST_MAC_ADDRESS;
  logic [7:0]       TX_TAG;
  logic [RW-1:0]    TX_RESULT;
  logic             BUSY;
  logic [15:0]      DROP_COUNT;
  logic [15:0]      TIMEOUT_COUNT;

  inference_job_scheduler #(.RESULT_WIDTH(RW), .TIMEOUT_CYCLES(100)) dut (
    .ACLK               (ACLK),
    .ARESET             (ARESET),
    .RX_DATA_FRAME      (RX_DATA_FRAME),
    .RX_SRC_IP_ADDRESS  (RX_SRC_IP_ADDRESS),
    .RX_SRC_MAC_ADDRESS (RX_SRC_MAC_ADDRESS),
    .RX_FRAME_READY     (RX_FRAME_READY),
    .CORE_START         (CORE_START),
    .CORE_IMAGE         (CORE_IMAGE),
    .CORE_DONE          (CORE_DONE),
    .CORE_RESULT        (CORE_RESULT),
    .TX_VALID           (TX_VALID),
    .TX_READY           (TX_READY),
    .TX_DST_IP_ADDRESS  (TX_DST_IP_ADDRESS),
    .TX_DST_MAC_ADDRESS (TX_DST_MAC_ADDRESS),
    .TX_TAG             (TX_TAG),
    .TX_RESULT          (TX_RESULT),
    .BUSY               (BUSY),
    .DROP_COUNT         (DROP_COUNT),
    .TIMEOUT_COUNT      (TIMEOUT_COUNT)
  );

  // ---------------- clock / reset ----------------
  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  int n_starts = 0;

  always @(negedge ACLK) if (CORE_START) n_starts++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [IMG_W-1:0] mk_img(input int seed);
    logic [IMG_W-1:0] img;
    for (int i = 0; i < IMAGE_BYTES; i++) img[i*8 +: 8] = 8'((seed * 37 + i * 11 + (i >> 3)) & 255);
    return img;
  endfunction

  task automatic chk_img(input string name, input int seed);
    chk(name, 64'(CORE_IMAGE === mk_img(seed)), 64'd1);
  endtask

  task automatic drive_rx(input logic [7:0] tag, input logic [31:0] ip, input logic [47:0] mac,
                          input int seed);
    RX_DATA_FRAME      = {mk_img(seed), tag};
    RX_SRC_IP_ADDRESS  = ip;
    RX_SRC_MAC_ADDRESS = mac;
    RX_FRAME_READY     = 1'b1;
  endtask

  task automatic clear_inputs();
    RX_FRAME_READY = 1'b0;
    CORE_DONE      = 1'b0;
    CORE_RESULT    = '0;
    TX_READY       = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    ARESET = 1'b0;
    repeat (3) tick();
    ARESET = 1'b1;
    tick();
  endtask

  task automatic pulse_done(input logic [RW-1:0] res);
    CORE_DONE   = 1'b1;
    CORE_RESULT = res;
    tick();
    CORE_DONE   = 1'b0;
    CORE_RESULT = '0;
  endtask

  task automatic handshake();
    TX_READY = 1'b1;
    tick();
    TX_READY = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]    tag;
    logic [31:0]   ip;
    logic [47:0]   mac;
    int            seed;
    logic [RW-1:0] res;
    int            delay;
    logic [31:0]   exp_ip;
    logic [47:0]   exp_mac;
    logic [7:0]    exp_tag;
    logic [RW-1:0] exp_res;
  } vec_t;

  typedef struct {
    logic [7:0]  tag;
    logic [31:0] ip;
    logic [47:0] mac;
    int          seed;
  } job_t;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  job_t          job_q[$];

  initial begin
    vec_t vecs[4];
    int   s0;
    int   drops;
    int   started;
    bit   core_busy;
    int   core_timer;
    logic [RW-1:0] core_res;
    job_t j;

    vecs[0] = '{8'h2A, 32'h0A000005, 48'h020000000005, 1, 8'h07, 50,
                32'h0A000005, 48'h020000000005, 8'h2A, 8'h07};
    vecs[1] = '{8'h00, 32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 2, 8'hFF, 1,
                32'hFFFFFFFF, 48'hFFFFFFFFFFFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 32'h00000000, 48'h000000000000, 3, 8'h00, 3,
                32'h00000000, 48'h000000000000, 8'hFF, 8'h00};
    vecs[3] = '{8'h5C, 32'hC0A80164, 48'hDEADBEEF0102, 4, 8'h80, 7,
                32'hC0A80164, 48'hDEADBEEF0102, 8'h5C, 8'h80};

    // Reset state
    clear_inputs();
    ARESET = 1'b0;
    tick();
    tick();
    chk("rst_core_start", CORE_START, 0);
    chk("rst_tx_valid", TX_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_drop", DROP_COUNT, 0);
    chk("rst_timeout", TIMEOUT_COUNT, 0);
    chk("rst_tx_ip", TX_DST_IP_ADDRESS, 0);
    chk("rst_tx_result", TX_RESULT, 0);
    ARESET = 1'b1;
    tick();

    // Single jobs from the table
    for (int v = 0; v < 4; v++) begin
      s0 = n_starts;
      drive_rx(vecs[v].tag, vecs[v].ip, vecs[v].mac, vecs[v].seed);
      tick();
      RX_FRAME_READY = 1'b0;
      chk("vec_start_n1", CORE_START, 1);
      chk("vec_busy_start", BUSY, 1);
      chk_img("vec_image", vecs[v].seed);
      tick();
      chk("vec_start_low_n2", CORE_START, 0);
      chk("vec_txv_run", TX_VALID, 0);
      repeat (vecs[v].delay - 1) tick();
      pulse_done(vecs[v].res);
      chk("vec_txv_m1", TX_VALID, 1);
      chk("vec_tx_ip", TX_DST_IP_ADDRESS, vecs[v].exp_ip);
      chk("vec_tx_mac", TX_DST_MAC_ADDRESS, vecs[v].exp_mac);
      chk("vec_tx_tag", TX_TAG, vecs[v].exp_tag);
      chk("vec_tx_result", TX_RESULT, vecs[v].exp_res);
      handshake();
      chk("vec_idle_k1", BUSY, 0);
      chk("vec_txv_low", TX_VALID, 0);
      chk("vec_one_start", n_starts - s0, 1);
    end

    // Back-pressure: outputs hold while TX_READY is low
    apply_reset();
    drive_rx(8'h11, 32'h01020304, 48'h0A0B0C0D0E0F, 10);
    tick();
    RX_FRAME_READY = 1'b0;
    tick();
    pulse_done(8'h42);
    s0 = n_starts;
    for (int c = 0; c < 20; c++) begin
      chk("bp_hold", 64'({TX_VALID, BUSY, TX_TAG, TX_RESULT} === {1'b1, 1'b1, 8'h11, 8'h42}), 1);
      chk("bp_addr", 64'({TX_DST_IP_ADDRESS, TX_DST_MAC_ADDRESS} ===
                         {32'h01020304, 48'h0A0B0C0D0E0F}), 1);
      tick();
    end
    chk("bp_no_restart", n_starts - s0, 0);
    handshake();
    chk("bp_idle", BUSY, 0);

    // Queue and drop
    apply_reset();
    drive_rx(8'hA1, 32'h0A000001, 48'h1, 20);
    tick();
    RX_FRAME_READY = 1'b0;
    tick();
    drive_rx(8'hB2, 32'h0A000002, 48'h2, 21);
    tick();
    drive_rx(8'hC3, 32'h0A000003, 48'h3, 22);
    tick();
    drive_rx(8'hD4, 32'h0A000004, 48'h4, 23);
    tick();
    RX_FRAME_READY = 1'b0;
    chk("qd_drop2", DROP_COUNT, 2);
    chk_img("qd_image_a_held", 20);
    pulse_done(8'h11);
    chk("qd_tx_tag_a", TX_TAG, 8'hA1);
    handshake();
    chk("qd_pending_start_k1", CORE_START, 1);
    chk_img("qd_image_b", 21);
    tick();
    pulse_done(8'h22);
    chk("qd_tx_tag_b", TX_TAG, 8'hB2);
    chk("qd_tx_ip_b", TX_DST_IP_ADDRESS, 32'h0A000002);
    chk("qd_tx_res_b", TX_RESULT, 8'h22);
    handshake();
    chk("qd_idle_after_b", BUSY, 0);
    chk("qd_drop_final", DROP_COUNT, 2);

    // Simultaneous drain and RX
    apply_reset();
    drive_rx(8'h31, 32'h0B000001, 48'h11, 30);
    tick();
    RX_FRAME_READY = 1'b0;
    tick();
    drive_rx(8'h32, 32'h0B000002, 48'h12, 31);
    tick();
    RX_FRAME_READY = 1'b0;
    pulse_done(8'h33);
    chk("sim_tx_tag_a", TX_TAG, 8'h31);
    drive_rx(8'h35, 32'h0B000003, 48'h13, 32);
    TX_READY = 1'b1;
    tick();
    RX_FRAME_READY = 1'b0;
    TX_READY = 1'b0;
    chk("sim_start_b", CORE_START, 1);
    chk_img("sim_image_b", 31);
    chk("sim_no_drop", DROP_COUNT, 0);
    tick();
    pulse_done(8'h44);
    chk("sim_tx_tag_b", TX_TAG, 8'h32);
    chk("sim_tx_res_b", TX_RESULT, 8'h44);
    handshake();
    chk("sim_start_c", CORE_START, 1);
    chk_img("sim_image_c", 32);
    tick();
    pulse_done(8'h55);
    chk("sim_tx_tag_c", TX_TAG, 8'h35);
    chk("sim_tx_mac_c", TX_DST_MAC_ADDRESS, 48'h13);
    handshake();
    chk("sim_idle", BUSY, 0);

    // Reset mid-RUN with a pending job
    apply_reset();
    drive_rx(8'h41, 32'h0C000001, 48'h21, 40);
    tick();
    RX_FRAME_READY = 1'b0;
    tick();
    drive_rx(8'h42, 32'h0C000002, 48'h22, 41);
    tick();
    RX_FRAME_READY = 1'b0;
    #2;
    ARESET = 1'b0;
    #1;
    chk("mr_busy", BUSY, 0);
    chk("mr_core_start", CORE_START, 0);
    chk("mr_tx_valid", TX_VALID, 0);
    chk("mr_tx_tag", TX_TAG, 0);
    chk("mr_tx_ip", TX_DST_IP_ADDRESS, 0);
    chk("mr_tx_mac", TX_DST_MAC_ADDRESS, 0);
    chk("mr_image_zero", 64'(CORE_IMAGE === '0), 1);
    tick();
    ARESET = 1'b1;
    s0 = n_starts;
    pulse_done(8'h99);
    chk("mr_done_ignored", TX_VALID, 0);
    repeat (3) tick();
    chk("mr_pending_gone", BUSY, 0);
    chk("mr_no_start", n_starts - s0, 0);
    chk("mr_tx_result", TX_RESULT, 0);

`ifdef INFER_SCHED_TIMEOUT_EN
    // Watchdog expiry, then CORE_DONE in the final watchdog cycle
    apply_reset();
    drive_rx(8'h61, 32'h0D000001, 48'h31, 50);
    tick();
    RX_FRAME_READY = 1'b0;
    tick();
    repeat (99) tick();
    chk("to_not_yet", TX_VALID, 0);
    tick();
    chk("to_send", TX_VALID, 1);
    chk("to_result_ff", TX_RESULT, 8'hFF);
    chk("to_count1", TIMEOUT_COUNT, 1);
    handshake();
    drive_rx(8'h62, 32'h0D000002, 48'h32, 51);
    tick();
    RX_FRAME_READY = 1'b0;
    tick();
    repeat (99) tick();
    pulse_done(8'h33);
    chk("to_done_wins_res", TX_RESULT, 8'h33);
    chk("to_done_wins_cnt", TIMEOUT_COUNT, 1);
    handshake();
`endif

    // Randomized traffic against a two-entry in-order job model
    apply_reset();
    drops = 0;
    started = 0;
    core_busy = 1'b0;
    core_timer = 0;
    core_res = '0;
    job_q.delete();
    exp_q.delete();
    for (int cyc = 0; cyc < 4000 || job_q.size() != 0; cyc++) begin
      if (cyc > 6000) begin
        chk("rand_drain_bounded", job_q.size(), 0);
        break;
      end
      RX_FRAME_READY = 1'b0;
      CORE_DONE      = 1'b0;
      if (CORE_START) begin
        chk("rand_start_has_job", 64'(started < job_q.size()), 1);
        if (started < job_q.size()) chk_img("rand_image", job_q[started].seed);
        started++;
        core_busy  = 1'b1;
        core_timer = $urandom_range(1, 12);
        core_res   = RW'($urandom);
      end else if (core_busy) begin
        core_timer--;
        if (core_timer == 0) begin
          CORE_DONE   = 1'b1;
          CORE_RESULT = core_res;
          exp_q.push_back(core_res);
          core_busy   = 1'b0;
        end
      end
      TX_READY = ($urandom_range(0, 3) != 0);
      if (TX_VALID && TX_READY) begin
        chk("rand_tx_has_job", 64'(job_q.size() != 0 && exp_q.size() != 0), 1);
        if (job_q.size() != 0 && exp_q.size() != 0) begin
          chk("rand_tx_tag", TX_TAG, job_q[0].tag);
          chk("rand_tx_ip", TX_DST_IP_ADDRESS, job_q[0].ip);
          chk("rand_tx_mac", TX_DST_MAC_ADDRESS, job_q[0].mac);
          chk("rand_tx_result", TX_RESULT, exp_q[0]);
          void'(job_q.pop_front());
          void'(exp_q.pop_front());
          started--;
        end
      end
      if (cyc < 4000 && $urandom_range(0, 2) == 0) begin
        j.tag  = 8'($urandom);
        j.ip   = $urandom;
        j.mac  = 48'({16'($urandom), $urandom});
        j.seed = cyc + 100;
        drive_rx(j.tag, j.ip, j.mac, j.seed);
        if (job_q.size() < 2) job_q.push_back(j);
        else drops++;
      end
      tick();
    end
    clear_inputs();
    chk("rand_drop_count", DROP_COUNT, 64'(drops));
    chk("rand_idle_end", BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
